seg7_scan_mux: RTL
==================

# seg7_scan_mux

Parametrised multiplexed 7-segment display driver; next generation of the team's 4-digit scanner. Time-multiplexes `NUM_DIGITS` hex nibbles onto one shared segment bus with a programmable per-digit dwell, inter-digit ghost-blanking, decimal points, per-digit blanking and leading-zero suppression. Sits between the datapath (counters/BCD converters) and the board's common-anode display pins. Input values are captured once per frame, so a refresh never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4: digits scanned; range 1–8.
- `DWELL_CYCLES`, 10000: clocks each digit stays lit; ≥1.
- `BLANK_CYCLES`, 16: clocks with all digits off between digits; 0 disables the blanking gap.
- `SEG_ACTIVE_LOW`, 1: 1 = segment lit when its bit is 0.
- `EN_ACTIVE_LOW`, 1: 1 = digit enabled when its bit is 0.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `digits` in 4*NUM_DIGITS: nibble i = `digits[4i+3:4i]`; digit 0 is the least significant (rightmost).
- `dp_in` in NUM_DIGITS: decimal point request per digit.
- `blank_mask` in NUM_DIGITS: 1 forces that digit dark.
- `lz_en` in 1: enables leading-zero suppression.
- `Leds7Seg` out 7: segments {g,f,e,d,c,b,a}, registered.
- `Dp` out 1: decimal point segment, registered, same polarity as `Leds7Seg`.
- `Enable7Seg` out NUM_DIGITS: one-hot digit enable, registered.
- `digit_idx` out ceil(log2(NUM_DIGITS)), min 1: index of the digit currently scanned.
- `frame_tick` out 1: one-cycle pulse when digit 0 becomes lit.

## Operation
- FSM states: `GAP` (all enables inactive, segments off) and `SHOW` (enable `digit_idx` active).
- A cycle counter `cnt` restarts at 0 on every state entry.
- `SHOW` → `GAP` when `cnt == DWELL_CYCLES-1`.
- `GAP` → `SHOW` when `cnt == BLANK_CYCLES-1`. On that transition, `digit_idx` advances with wrap-around NUM_DIGITS-1 → 0.
- If `BLANK_CYCLES == 0`, `GAP` is never entered. `SHOW` advances directly to the next digit's `SHOW`.
- Snapshot:
  - `digits`, `dp_in`, `blank_mask` and `lz_en` are copied into shadow registers on the cycle `digit_idx` wraps to 0.
  - All display decisions use the shadow copy only.
- Leading-zero suppression (shadow `lz_en` = 1):
  - Digit i > 0 is dark when its nibble and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows its dp if its `dp_in` is set.
- Blanked digit (`blank_mask`): segments and dp off. The enable is still asserted, so scan timing is unchanged.
- Decode, shown active-high as gfedcba before polarity inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- "Off" means all segment bits at the inactive level: 7'b1111111 when `SEG_ACTIVE_LOW`=1.
- Parameter range errors are caught by elaboration-time checks; out-of-range values are not supported.

## Timing
- Reset (async assert, sync release):
  - state = `GAP`, `cnt` = 0, `digit_idx` = NUM_DIGITS-1.
  - `Enable7Seg` all inactive, `Leds7Seg`/`Dp` off, `frame_tick` = 0, shadow registers = 0.
- After reset, the first transition lights digit 0 and takes a snapshot:
  - `BLANK_CYCLES` > 0: after `BLANK_CYCLES` edges.
  - `BLANK_CYCLES` = 0: on the first edge.
- All outputs are registered and change only on `clk` edges.
- `Enable7Seg`, `Leds7Seg`, `Dp` and `digit_idx` update on the same edge; no segment/enable skew.
- Input-to-display latency: the change is shown from the next frame start. Worst case is one full frame plus one cycle.
- Frame period = NUM_DIGITS × (DWELL_CYCLES + BLANK_CYCLES) cycles.
- `frame_tick` is high exactly on the first `SHOW` cycle of digit 0.
- Inputs changing mid-frame have no visible effect until the next wrap.
- Reset mid-frame immediately blanks all outputs (asynchronous), then restarts as above.
- `NUM_DIGITS` = 1: `digit_idx` is constantly 0 and a snapshot is taken on every `GAP`→`SHOW` transition.

## Test plan
- **Reset and first frame.** Default parameters, `digits`=16'h1234, assert then release `reset`.
  - Enables 4'b1111 and segments 7'b1111111 for 16 cycles.
  - Then `Enable7Seg`=4'b1110, `Leds7Seg`=7'b0011001 ("4"), `frame_tick` for one cycle.
- **Scan order and timing.** DWELL=4, BLANK=2.
  - Enables follow 1110 ×4, 1111 ×2, 1101 ×4, 1111 ×2, 1011, 0111, then back to 1110.
  - `frame_tick` repeats every 24 cycles.
- **Leading zeros.** `digits`=16'h0070, `lz_en`=1.
  - Digits 3 and 2 dark, digit 1 = 7'b1111000, digit 0 = 7'b1000000.
  - With `lz_en`=0, digits 3 and 2 show 7'b1000000.
- **No tearing.** Change `digits` from 16'h1111 to 16'h2222 while digit 2 is lit.
  - Digits 2 and 3 still show "1" in that frame.
  - All digits show "2" from the next `frame_tick`.
- **Blank and dp.** `blank_mask`=4'b0100, `dp_in`=4'b0100.
  - Digit 2 enable asserted, `Leds7Seg`=7'b1111111, `Dp`=1.
  - `dp_in` alone on a suppressed zero digit gives `Dp`=0.
- **Reset mid-operation.** Pulse `reset` during the digit 1 dwell.
  - Outputs go inactive asynchronously, before the next edge.
  - The sequence restarts from the post-reset `GAP`; `BLANK_CYCLES`=0 is also covered, with no all-off cycles between digits.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scanner: per-frame input snapshot, programmable dwell and
// ghost-blanking gap, decimal points, per-digit blanking and leading-zero suppression.
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 10000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit EN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [6:0]              Leds7Seg,
  output logic                    Dp,
  output logic [NUM_DIGITS-1:0]   Enable7Seg,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = EN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_mux: NUM_DIGITS must be in 1..8");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("seg7_scan_mux: DWELL_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 0) begin : g_bad_blank
    $error("seg7_scan_mux: BLANK_CYCLES must be >= 0");
  end

  typedef enum logic {GAP, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                    sh_lz_q, sh_lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    tick_q, tick_d;

  logic                    enter_show;
  logic                    wrap;
  logic                    higher_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dark, cur_dp, cur_blank;
  logic [6:0]              seg_lit;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    enter_show = 1'b0;
    unique case (state_q)
      GAP: begin
        if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
          state_d    = SHOW;
          cnt_d      = '0;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            enter_show = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
    endcase
    if (enter_show) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign wrap        = enter_show && (idx_d == '0);
  assign sh_digits_d = wrap ? digits     : sh_digits_q;
  assign sh_dp_d     = wrap ? dp_in      : sh_dp_q;
  assign sh_blank_d  = wrap ? blank_mask : sh_blank_q;
  assign sh_lz_d     = wrap ? lz_en      : sh_lz_q;
  assign tick_d      = wrap;
  assign onehot      = NUM_DIGITS'(1) << idx_d;

  // Scan from the top digit down so higher_zero means "this and every higher nibble is 0".
  always_comb begin
    higher_zero = 1'b1;
    cur_nib     = '0;
    cur_dark    = 1'b0;
    cur_dp      = 1'b0;
    cur_blank   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (sh_digits_d[4*i +: 4] == 4'h0);
      if (idx_d == IDX_W'(i)) begin
        cur_nib   = sh_digits_d[4*i +: 4];
        cur_dark  = sh_lz_d && higher_zero && (i != 0);
        cur_dp    = sh_dp_d[i];
        cur_blank = sh_blank_d[i];
      end
    end
  end

  // NOTE: outputs are decoded from next-state values so enable, segments and index land on the same edge as the state.
  always_comb begin
    seg_lit = 7'h00;
    dp_lit  = 1'b0;
    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    en_d    = EN_OFF;
    if (state_d == SHOW) begin
      seg_lit = (cur_blank || cur_dark) ? 7'h00 : hex_to_seg(cur_nib);
      dp_lit  = cur_dp && !cur_blank;
      seg_d   = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      dp_d    = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
      en_d    = EN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; shadow copies are reset so a frame never shows stale garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= GAP;
      cnt_q       <= '0;
      idx_q       <= IDX_LAST;
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lz_q     <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      en_q        <= EN_OFF;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_lz_q     <= sh_lz_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      en_q        <= en_d;
      tick_q      <= tick_d;
    end
  end

  assign Leds7Seg   = seg_q;
  assign Dp         = dp_q;
  assign Enable7Seg = en_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule
